// File: rtl/sprite_layer_engine_if.sv
// Descriptor write port for sprite_layer_engine: valid/ready handshake carrying slot index and packed descriptor.
interface sprite_layer_engine_if #(
  parameter int SLOT_BITS = 3
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [SLOT_BITS-1:0] wr_slot;
  logic [31:0]          wr_data;

  modport master (output wr_valid, wr_slot, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_slot, wr_data, output wr_ready);
endinterface

// File: rtl/sprite_layer_engine.sv
// Multi-slot sprite hit test with shadow/active descriptor sets and a frame-start commit FSM.
// Optional collision tracking is built when COLLISION_DETECT_EN is defined.
//
// state  | meaning
// IDLE   | accepting descriptor writes; commit on frame_start when dirty
// COMMIT | copying shadow[cnt] -> active[cnt], one slot per cycle; writes stalled
module sprite_layer_engine #(
  parameter int N_SLOTS      = 8,
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 10,
  parameter int SPRITE_W     = 20,
  parameter int SPRITE_H     = 20,
  parameter int OFFSET_BITS  = 6,
  parameter int SIZE_ADDRESS = 14,
  parameter int SLOT_BITS    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pixel_en,
  input  logic                    active_area,
  input  logic [SIZE_X-1:0]       pixel_x,
  input  logic [SIZE_Y-1:0]       pixel_y,
  input  logic                    frame_start,
  sprite_layer_engine_if.slave    wr,
  output logic                    sprite_on,
  output logic [SLOT_BITS-1:0]    sprite_slot,
  output logic [SIZE_ADDRESS-1:0] memory_address,
  output logic                    addr_valid,
  output logic                    collision,
  output logic [N_SLOTS-1:0]      collision_mask
);
  typedef enum logic {IDLE, COMMIT} state_t;

  localparam logic [SIZE_X:0] SPR_W_X = (SIZE_X+1)'(SPRITE_W);
  localparam logic [SIZE_Y:0] SPR_H_Y = (SIZE_Y+1)'(SPRITE_H);

  state_t               state;
  logic [SLOT_BITS-1:0] cnt;
  logic                 dirty;

  logic                   sh_en  [N_SLOTS];
  logic [SIZE_X-1:0]      sh_x   [N_SLOTS];
  logic [SIZE_Y-1:0]      sh_y   [N_SLOTS];
  logic [OFFSET_BITS-1:0] sh_off [N_SLOTS];
  logic                   act_en [N_SLOTS];
  logic [SIZE_X-1:0]      act_x  [N_SLOTS];
  logic [SIZE_Y-1:0]      act_y  [N_SLOTS];
  logic [OFFSET_BITS-1:0] act_off[N_SLOTS];

  logic wr_accept;
  logic unused_wr_bits;
  assign wr_accept      = wr.wr_valid && wr.wr_ready && (32'(wr.wr_slot) < 32'(N_SLOTS));
  assign unused_wr_bits = ^wr.wr_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dirty       <= 1'b0;
      wr.wr_ready <= 1'b1;
      for (int s = 0; s < N_SLOTS; s++) begin
        sh_en[s]   <= 1'b0;
        sh_x[s]    <= '0;
        sh_y[s]    <= '0;
        sh_off[s]  <= '0;
        act_en[s]  <= 1'b0;
        act_x[s]   <= '0;
        act_y[s]   <= '0;
        act_off[s] <= '0;
      end
    end else begin
      if (wr_accept) begin
        sh_en[wr.wr_slot]  <= wr.wr_data[31];
        sh_x[wr.wr_slot]   <= SIZE_X'(wr.wr_data[30:21]);
        sh_y[wr.wr_slot]   <= SIZE_Y'(wr.wr_data[20:11]);
        sh_off[wr.wr_slot] <= wr.wr_data[OFFSET_BITS-1:0];
        dirty              <= 1'b1;
      end
      case (state)
        IDLE: begin
          // a write landing on the frame_start edge is already in shadow when the copy begins
          if (frame_start && (dirty || wr_accept)) begin
            state       <= COMMIT;
            cnt         <= '0;
            wr.wr_ready <= 1'b0;
          end
        end
        COMMIT: begin
          act_en[cnt]  <= sh_en[cnt];
          act_x[cnt]   <= sh_x[cnt];
          act_y[cnt]   <= sh_y[cnt];
          act_off[cnt] <= sh_off[cnt];
          if (cnt == SLOT_BITS'(N_SLOTS-1)) begin
            state       <= IDLE;
            dirty       <= 1'b0;
            wr.wr_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [N_SLOTS-1:0]   hit;
  logic [SLOT_BITS-1:0] win;
  logic                 any_hit;

  always_comb begin
    hit     = '0;
    win     = '0;
    any_hit = 1'b0;
    for (int s = 0; s < N_SLOTS; s++) begin
      hit[s] = act_en[s] && active_area &&
               (pixel_x >= act_x[s]) && ({1'b0, pixel_x} < {1'b0, act_x[s]} + SPR_W_X) &&
               (pixel_y >= act_y[s]) && ({1'b0, pixel_y} < {1'b0, act_y[s]} + SPR_H_Y);
    end
    for (int s = N_SLOTS-1; s >= 0; s--) begin
      if (hit[s]) begin
        win     = SLOT_BITS'(s);
        any_hit = 1'b1;
      end
    end
  end

  logic                    s1_valid, s1_on;
  logic [SLOT_BITS-1:0]    s1_slot;
  logic [SIZE_X-1:0]       s1_dx;
  logic [SIZE_Y-1:0]       s1_dy;
  logic [OFFSET_BITS-1:0]  s1_off;
  logic                    s2_valid, s2_on;
  logic [SLOT_BITS-1:0]    s2_slot;
  logic [SIZE_ADDRESS-1:0] s2_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid       <= 1'b0;
      s1_on          <= 1'b0;
      s1_slot        <= '0;
      s1_dx          <= '0;
      s1_dy          <= '0;
      s1_off         <= '0;
      s2_valid       <= 1'b0;
      s2_on          <= 1'b0;
      s2_slot        <= '0;
      s2_addr        <= '0;
      addr_valid     <= 1'b0;
      sprite_on      <= 1'b0;
      sprite_slot    <= '0;
      memory_address <= '0;
    end else begin
      s1_valid <= pixel_en;
      if (pixel_en) begin
        s1_on   <= any_hit;
        s1_slot <= win;
        s1_dx   <= any_hit ? pixel_x - act_x[win] : '0;
        s1_dy   <= any_hit ? pixel_y - act_y[win] : '0;
        s1_off  <= any_hit ? act_off[win] : '0;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_on   <= s1_on;
        s2_slot <= s1_slot;
        s2_addr <= s1_on ? SIZE_ADDRESS'(32'(s1_off) * 32'(SPRITE_W * SPRITE_H) +
                                         32'(s1_dy) * 32'(SPRITE_W) + 32'(s1_dx)) : '0;
      end
      addr_valid <= s2_valid;
      if (s2_valid) begin
        sprite_on      <= s2_on;
        sprite_slot    <= s2_slot;
        memory_address <= s2_addr;
      end
    end
  end

`ifdef COLLISION_DETECT_EN
  logic multi_hit;
  assign multi_hit = |(hit & (hit - N_SLOTS'(1)));

  // a collision on the frame_start edge survives the clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      collision_mask <= '0;
    end else if (pixel_en && multi_hit) begin
      collision_mask <= (frame_start ? '0 : collision_mask) | hit;
    end else if (frame_start) begin
      collision_mask <= '0;
    end
  end
  assign collision = |collision_mask;
`else
  assign collision      = 1'b0;
  assign collision_mask = '0;
`endif
endmodule

// File: doc/sprite_layer_engine.md
Name: sprite_layer_engine

Overview:
Multi-slot successor to the single-sprite print path: holds N_SLOTS sprite descriptors and resolves every visible pixel to a sprite-ROM address, or reports "no sprite". Descriptors are written through a valid/ready port into shadow registers. The shadow registers are copied into the active set by a commit FSM at frame start, so mid-frame writes never tear. The block runs on one system clock; pixel timing arrives as a pixel_en strobe. It sits between the VGA sync generator and the sprite memory / colour mux.

Parameters:
N_SLOTS, 8, number of sprite descriptor slots (1..32)
SIZE_X, 10, pixel_x / descriptor x width
SIZE_Y, 10, pixel_y / descriptor y width
SPRITE_W, 20, sprite width in pixels
SPRITE_H, 20, sprite height in pixels
OFFSET_BITS, 6, sprite-image index width
SIZE_ADDRESS, 14, memory address width
SLOT_BITS, 3, width of slot index (>= clog2(N_SLOTS))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
pixel_en  in  1  one-cycle strobe: pixel_x/pixel_y/active_area valid
active_area  in  1  visible-region flag
pixel_x  in  SIZE_X  current column
pixel_y  in  SIZE_Y  current row
frame_start  in  1  one-cycle pulse in vertical blanking
wr_valid  in  1  descriptor write request
wr_ready  out  1  block can accept a write
wr_slot  in  SLOT_BITS  target slot
wr_data  in  32  [31]=enable, [30:21]=x, [20:11]=y, [OFFSET_BITS-1:0]=image index; other bits ignored
sprite_on  out  1  current pixel is covered by a sprite
sprite_slot  out  SLOT_BITS  winning slot index
memory_address  out  SIZE_ADDRESS  sprite ROM address
addr_valid  out  1  one-cycle pulse: outputs updated
collision  out  1  see Optional Feature
collision_mask  out  N_SLOTS  see Optional Feature

Behaviour:
- Reset (reset==0 at a clk edge): all shadow and active slots have enable=0, x=y=offset=0. dirty=0. FSM=IDLE. wr_ready=1. sprite_on=0, sprite_slot=0, memory_address=0, addr_valid=0, collision=0, collision_mask=0. Reset asserted mid-commit or mid-pipeline aborts the operation immediately.
- Write port: a transfer happens when wr_valid && wr_ready at a clk edge. It writes the shadow slot and sets dirty. If wr_slot >= N_SLOTS, the transfer is accepted and discarded, and dirty is unchanged. If the same slot is written repeatedly before a commit, the last write wins.
- FSM IDLE: wr_ready=1. On frame_start && dirty, go to COMMIT and clear the counter. A write accepted in the same cycle as frame_start is included in that commit. On frame_start && !dirty, stay in IDLE.
- FSM COMMIT: wr_ready=0. Each cycle, copy shadow[cnt] to active[cnt] and increment cnt. After slot N_SLOTS-1 is copied, clear dirty and return to IDLE. A commit takes exactly N_SLOTS cycles. frame_start during COMMIT is ignored.
- Hit test, stage 1: registered on a clk edge where pixel_en=1. For each active slot s, hit[s] = enable && active_area && x <= pixel_x < x+SPRITE_W && y <= pixel_y < y+SPRITE_H. Sums are computed at width+1 bits so there is no wrap; a sprite near the right edge is simply clipped. Lowest hit index wins (fixed priority). Stage 1 also registers dx=pixel_x-x and dy=pixel_y-y for the winner.
- Stage 2: memory_address = offset*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx, truncated modulo 2^SIZE_ADDRESS.
- Latency: pixel_en sampled at edge t, so outputs change at edge t+2 and addr_valid=1 for exactly the cycle after t+2. pixel_en strobes must be at least 1 cycle apart; back-to-back strobes are pipelined, one result per strobe.
- No hit (or active_area=0): sprite_on=0, sprite_slot=0, memory_address=0, addr_valid still pulses.
- Outputs hold their value between addr_valid pulses.
- Pixel evaluation during COMMIT uses the active array as partially updated. This is legal only because frame_start is issued in blanking.

Optional Feature:
COLLISION_DETECT_EN. When defined: collision_mask |= hit vector whenever two or more slots hit the same pixel, and collision = |collision_mask. Both are sticky and clear on the frame_start edge; a collision in the same cycle takes precedence and is kept. When undefined: collision and collision_mask are tied to 0, and no counting logic is generated.

Test Plan:
- Reset, then pixel_en at (0,0) with active_area=1 -> after 2 cycles addr_valid=1, sprite_on=0, memory_address=0.
- Write slot 2 {en=1, x=100, y=50, off=3}, frame_start, wait 8 cycles, pixel (105,52) -> sprite_on=1, slot=2, address=3*400+2*20+5=1245. Pixel (120,52) -> sprite_on=0.
- Slots 1 and 4 overlap at (200,200) -> sprite_slot=1. With COLLISION_DETECT_EN: collision=1, collision_mask=8'b0001_0010, cleared by the next frame_start.
- Write slot 0 x=300 without frame_start, then pixel at (305,y) -> old position still used. After frame_start, wr_ready=0 for exactly 8 cycles, then new position used.
- Sprite at x=1015 with pixel_x=1023 -> hit, dx=8. pixel_x=1034 is unreachable, so there is no false hit from wrap. Also check off=40 -> address (16000+...) mod 16384.
- Assert reset mid-COMMIT (cycle 3) -> wr_ready=1, all active enables=0, sprite_on=0 on the next pixel.
